// File: rtl/pcs_40g_tx_gearbox.sv
// 66b-to-64b transmit gearbox for the 40G PCS. Each lane turns one 66-bit block per cycle into a
// continuous 64-bit word stream, LSB first. Every 33rd cycle the gearbox drains its residual and
// stalls the PCS through ready_o. All lanes share one sequence counter and run in lockstep.
module pcs_40g_tx_gearbox #(
  parameter int unsigned LANE_N = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned HEAD_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic [LANE_N*DATA_W-1:0] data_o,
  output logic                     valid_o
);

  localparam int unsigned BLK_W  = DATA_W + HEAD_W;
  // Blocks accepted per period; one extra drain cycle makes the period PERIOD+1 cycles long.
  localparam int unsigned PERIOD = DATA_W / HEAD_W;
  localparam int unsigned SEQ_W  = $clog2(PERIOD + 1);
  localparam int unsigned SH_W   = $clog2(2 * DATA_W);
  // Residual (at most DATA_W-HEAD_W bits) plus one block always fits in two output words.
  localparam int unsigned WIDE_W = 2 * DATA_W;

  logic [SEQ_W-1:0] seq_q;
  logic             drain;
  logic [SH_W-1:0]  shamt;
  logic             valid_q;

  // On the drain cycle the residual holds exactly one full word and the input is ignored.
  assign drain   = (seq_q == SEQ_W'(PERIOD));
  assign ready_o = ~drain;
  // Number of residual bits already queued ahead of this cycle's block.
  assign shamt   = SH_W'(seq_q) * SH_W'(HEAD_W);

  // Shared sequence counter, 0..PERIOD, wrapping after the drain cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q <= '0;
    end else if (drain) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_q + 1'b1;
    end
  end

  // Output qualifier: low only from reset until the first word after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
    end
  end

  assign valid_o = valid_q;

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    logic [BLK_W-1:0]  blk;
    logic [WIDE_W-1:0] stream;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] res_d;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;

    // Header occupies the low bits so it is the first thing on the wire.
    assign blk = {data_i[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]};

    // Append the new block above the residual; bits above the residual's valid count are
    // always zero, so a plain OR merges the two.
    always_comb begin
      stream = (WIDE_W'(blk) << shamt) | WIDE_W'(res_q);
      if (drain) begin
        word_d = res_q;
        res_d  = '0;
      end else begin
        word_d = stream[DATA_W-1:0];
        res_d  = stream[WIDE_W-1:DATA_W];
      end
    end

    // Per-lane residual and registered output word.
    always_ff @(posedge clk) begin
      if (reset) begin
        res_q  <= '0;
        word_q <= '0;
      end else begin
        res_q  <= res_d;
        word_q <= word_d;
      end
    end

    assign data_o[l*DATA_W +: DATA_W] = word_q;
  end

endmodule

// File: tb/tb_pcs_40g_tx_gearbox.sv
// Bench for the 66b-to-64b transmit gearbox. The reference keeps each lane's wire stream as a
// queue of bits: accepted blocks are appended LSB first, and each cycle the next 64 bits are
// popped as the expected output word. ready is expected low whenever a full word is already
// queued before the block arrives.
module tb_pcs_40g_tx_gearbox;

  localparam int LN = 4;
  localparam int DW = 64;
  localparam int HW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [LN*HW-1:0] head_i;
  logic [LN*DW-1:0] data_i;
  logic             ready_o;
  logic [LN*DW-1:0] data_o;
  logic             valid_o;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  bit          bq [LN][$];
  logic [DW-1:0] exp_word [LN];
  logic        exp_valid = 1'b0;

  pcs_40g_tx_gearbox #(
    .LANE_N (LN),
    .DATA_W (DW),
    .HEAD_W (HW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .head_i  (head_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference update for one rising edge, using the inputs the DUT samples on that edge.
  task automatic model_edge();
    if (reset) begin
      for (int l = 0; l < LN; l++) begin
        bq[l].delete();
        exp_word[l] = '0;
      end
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b1;
      for (int l = 0; l < LN; l++) begin
        logic [DW+HW-1:0] blk;
        logic [DW-1:0]    w;
        if (bq[l].size() < DW) begin
          blk = {data_i[l*DW +: DW], head_i[l*HW +: HW]};
          for (int b = 0; b < DW + HW; b++) bq[l].push_back(blk[b]);
        end
        for (int b = 0; b < DW; b++) w[b] = bq[l].pop_front();
        exp_word[l] = w;
      end
    end
  endtask

  // One clock: inputs were set at the preceding falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_rand();
    for (int l = 0; l < LN; l++) begin
      data_i[l*DW +: DW] = {$urandom, $urandom};
      head_i[l*HW +: HW] = 2'($urandom_range(1, 2));
    end
  endtask

  // Continuous comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk1("valid", valid_o, exp_valid);
      chk1("ready", ready_o, bq[0].size() < DW);
      for (int l = 0; l < LN; l++) begin
        chk64($sformatf("data lane%0d", l), data_o[l*DW +: DW], exp_word[l]);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    head_i = '0;
    data_i = '0;

    // Reset held for three cycles.
    repeat (3) begin
      cyc();
      for (int l = 0; l < LN; l++) chk64("reset data", data_o[l*DW +: DW], 64'h0);
      chk1("reset valid", valid_o, 1'b0);
      chk1("reset ready", ready_o, 1'b1);
    end

    // Release; known block on lane 0 first, random afterwards; ready cadence over two periods.
    reset = 1'b0;
    for (int i = 1; i <= 66; i++) begin
      chk1("ready cadence", ready_o, (i % 33) != 0);
      set_rand();
      if (i == 1) begin
        head_i[1:0]  = 2'b01;
        data_i[63:0] = 64'h0123456789ABCDEF;
      end
      cyc();
      if (i == 1) chk64("lane0 first word", data_o[63:0], 64'h048D159E26AF37BD);
      if (i == 2) chk64("lane0 residual bits", 64'(data_o[1:0]), 64'h0);
    end

    // All-ones payload, header 10, three full periods from an aligned start.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 1; i <= 99; i++) begin
      head_i = {LN{2'b10}};
      data_i = '1;
      cyc();
      for (int l = 0; l < LN; l++) begin
        if (i == 1) chk64("ones word0", data_o[l*DW +: DW], 64'hFFFFFFFFFFFFFFFE);
        if (i == 33) chk64("ones drain word", data_o[l*DW +: DW], 64'hFFFFFFFFFFFFFFFF);
      end
    end

    // Garbage driven only while the gearbox is stalling.
    for (int i = 0; i < 70; i++) begin
      if (bq[0].size() < DW) begin
        set_rand();
      end else begin
        head_i = '1;
        data_i = {LN{64'hDEADBEEFDEADBEEF}};
      end
      cyc();
    end

    // Reset asserted mid-period at seq=17.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (17) begin
      set_rand();
      cyc();
    end
    reset = 1'b1;
    set_rand();
    cyc();
    chk64("midreset data", data_o[63:0], 64'h0);
    chk1("midreset valid", valid_o, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      chk1("ready after midreset", ready_o, i != 33);
      if (i == 1) begin
        head_i = {LN{2'b01}};
        data_i = {LN{64'hA5A50F0F12345678}};
      end else begin
        set_rand();
      end
      cyc();
      if (i == 1) chk64("restart word", data_o[63:0], 64'h96943C3C48D159E1);
    end

    // Distinct per-lane patterns with alternating headers.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      for (int l = 0; l < LN; l++) begin
        data_i[l*DW +: DW] = {16{4'(l)}};
        head_i[l*HW +: HW] = (((c + l) % 2) != 0) ? 2'b10 : 2'b01;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
